// File: rtl/msrv32_dbus_arbiter.sv
// Two-master data-bus sequencer: arbitrates core (port 0) and secondary (port 1)
// requests and runs each as a single AHB-lite address/data transfer.
module msrv32_dbus_arbiter #(
  parameter int unsigned CORE_PRIORITY = 0
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        p0_req_in,
  input  logic        p0_wr_in,
  input  logic [31:0] p0_addr_in,
  input  logic [31:0] p0_wdata_in,
  input  logic [3:0]  p0_mask_in,
  input  logic        p1_req_in,
  input  logic        p1_wr_in,
  input  logic [31:0] p1_addr_in,
  input  logic [31:0] p1_wdata_in,
  input  logic [3:0]  p1_mask_in,
  output logic        p0_gnt_out,
  output logic        p1_gnt_out,
  output logic        p0_done_out,
  output logic        p1_done_out,
  output logic        p0_err_out,
  output logic        p1_err_out,
  output logic [31:0] rdata_out,
  output logic [31:0] ahb_haddr_out,
  output logic [1:0]  ahb_htrans_out,
  output logic        ahb_hwrite_out,
  output logic [31:0] ahb_hwdata_out,
  output logic [3:0]  ahb_wr_mask_out,
  input  logic        ahb_hready_in,
  input  logic        ahb_hresp_in,
  input  logic [31:0] ahb_hrdata_in
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        wr_q, wr_d;
  logic        port_q, port_d;
  logic        last_q, last_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic        any_req;
  logic        win;
  logic        grant;

  // On a tie, round-robin favours the port that did not win last time.
  always_comb begin
    any_req = p0_req_in | p1_req_in;
    if (p0_req_in && p1_req_in) begin
      win = (CORE_PRIORITY != 0) ? 1'b0 : ~last_q;
    end else begin
      win = p1_req_in;
    end
    grant = (state_q == S_IDLE) && any_req && ms_riscv32_mp_rst_n_in;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mask_d  = mask_q;
    wr_d    = wr_q;
    port_d  = port_q;
    last_d  = last_q;
    done_d  = '0;
    err_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          addr_d  = win ? p1_addr_in  : p0_addr_in;
          wdata_d = win ? p1_wdata_in : p0_wdata_in;
          mask_d  = win ? p1_mask_in  : p0_mask_in;
          wr_d    = win ? p1_wr_in    : p0_wr_in;
          port_d  = win;
          last_d  = win;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ahb_hready_in) state_d = S_DATA;
      end
      S_DATA: begin
        if (ahb_hready_in) begin
          done_d[port_q] = 1'b1;
          err_d[port_q]  = ahb_hresp_in;
          if (!wr_q) rdata_d = ahb_hrdata_in;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mask_q  <= '0;
      wr_q    <= 1'b0;
      port_q  <= 1'b0;
      last_q  <= 1'b1;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mask_q  <= mask_d;
      wr_q    <= wr_d;
      port_q  <= port_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    p0_gnt_out      = grant & ~win;
    p1_gnt_out      = grant & win;
    p0_done_out     = done_q[0];
    p1_done_out     = done_q[1];
    p0_err_out      = err_q[0];
    p1_err_out      = err_q[1];
    rdata_out       = rdata_q;
    ahb_haddr_out   = addr_q;
    ahb_htrans_out  = (state_q == S_ADDR) ? 2'b10 : 2'b00;
    ahb_hwrite_out  = wr_q;
    ahb_hwdata_out  = wdata_q;
    ahb_wr_mask_out = (state_q == S_DATA && wr_q) ? mask_q : '0;
  end

endmodule

// File: tb/tb_msrv32_dbus_arbiter.sv
// Bench for msrv32_dbus_arbiter: transaction-level model checked every cycle
// plus directed scenarios with hand-computed cycle/value expectations.
module tb_msrv32_dbus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p1_req, p0_wr, p1_wr;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic [3:0]  p0_mask, p1_mask;
  logic        hready, hresp;
  logic [31:0] hrdata;

  logic        d0_p0_gnt, d0_p1_gnt, d0_p0_done, d0_p1_done, d0_p0_err, d0_p1_err;
  logic [31:0] d0_rdata, d0_haddr, d0_hwdata;
  logic [1:0]  d0_htrans;
  logic        d0_hwrite;
  logic [3:0]  d0_mask;
  logic        d1_p0_gnt, d1_p1_gnt, d1_p0_done, d1_p1_done, d1_p0_err, d1_p1_err;
  logic [31:0] d1_rdata, d1_haddr, d1_hwdata;
  logic [1:0]  d1_htrans;
  logic        d1_hwrite;
  logic [3:0]  d1_mask;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  msrv32_dbus_arbiter #(.CORE_PRIORITY(0)) dut0 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
    .p0_req_in(p0_req), .p0_wr_in(p0_wr), .p0_addr_in(p0_addr), .p0_wdata_in(p0_wdata), .p0_mask_in(p0_mask),
    .p1_req_in(p1_req), .p1_wr_in(p1_wr), .p1_addr_in(p1_addr), .p1_wdata_in(p1_wdata), .p1_mask_in(p1_mask),
    .p0_gnt_out(d0_p0_gnt), .p1_gnt_out(d0_p1_gnt), .p0_done_out(d0_p0_done), .p1_done_out(d0_p1_done),
    .p0_err_out(d0_p0_err), .p1_err_out(d0_p1_err), .rdata_out(d0_rdata),
    .ahb_haddr_out(d0_haddr), .ahb_htrans_out(d0_htrans), .ahb_hwrite_out(d0_hwrite),
    .ahb_hwdata_out(d0_hwdata), .ahb_wr_mask_out(d0_mask),
    .ahb_hready_in(hready), .ahb_hresp_in(hresp), .ahb_hrdata_in(hrdata)
  );

  msrv32_dbus_arbiter #(.CORE_PRIORITY(1)) dut1 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
    .p0_req_in(p0_req), .p0_wr_in(p0_wr), .p0_addr_in(p0_addr), .p0_wdata_in(p0_wdata), .p0_mask_in(p0_mask),
    .p1_req_in(p1_req), .p1_wr_in(p1_wr), .p1_addr_in(p1_addr), .p1_wdata_in(p1_wdata), .p1_mask_in(p1_mask),
    .p0_gnt_out(d1_p0_gnt), .p1_gnt_out(d1_p1_gnt), .p0_done_out(d1_p0_done), .p1_done_out(d1_p1_done),
    .p0_err_out(d1_p0_err), .p1_err_out(d1_p1_err), .rdata_out(d1_rdata),
    .ahb_haddr_out(d1_haddr), .ahb_htrans_out(d1_htrans), .ahb_hwrite_out(d1_hwrite),
    .ahb_hwdata_out(d1_hwdata), .ahb_wr_mask_out(d1_mask),
    .ahb_hready_in(hready), .ahb_hresp_in(hresp), .ahb_hrdata_in(hrdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model of the round-robin instance: a transfer is in its
  // address phase until the first hready=1 edge, in its data phase until the
  // second, and its done pulse appears the cycle after that.
  logic        m_busy = 1'b0;
  int          m_hcnt = 0;
  logic        m_port = 1'b0;
  logic        m_last = 1'b1;
  logic        m_wr = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [3:0]  m_mask = '0;
  logic [1:0]  m_done = '0, m_err = '0;
  logic        m_rdone = 1'b0;

  initial begin
    forever begin
      logic       any, w;
      logic [1:0] egnt;
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_htrans", 32'(d0_htrans), 32'd0);
        chk("rst_haddr", d0_haddr, 32'd0);
        chk("rst_hwdata", d0_hwdata, 32'd0);
        chk("rst_mask", 32'(d0_mask), 32'd0);
        chk("rst_hwrite", 32'(d0_hwrite), 32'd0);
        chk("rst_rdata", d0_rdata, 32'd0);
        chk("rst_gnt", 32'({d0_p1_gnt, d0_p0_gnt}), 32'd0);
        chk("rst_done", 32'({d0_p1_done, d0_p0_done}), 32'd0);
        chk("rst_err", 32'({d0_p1_err, d0_p0_err}), 32'd0);
        m_busy = 1'b0; m_hcnt = 0; m_last = 1'b1; m_done = '0; m_err = '0;
        m_rdone = 1'b0; m_rdata = '0;
      end else begin
        any  = p0_req | p1_req;
        w    = (p0_req && p1_req) ? ~m_last : p1_req;
        egnt = '0;
        if (!m_busy && any) egnt = w ? 2'b10 : 2'b01;
        chk("m_gnt", 32'({d0_p1_gnt, d0_p0_gnt}), 32'(egnt));
        chk("m_done", 32'({d0_p1_done, d0_p0_done}), 32'(m_done));
        chk("m_err", 32'({d0_p1_err, d0_p0_err}), 32'(m_err));
        chk("m_htrans", 32'(d0_htrans), (m_busy && m_hcnt == 0) ? 32'd2 : 32'd0);
        if (m_busy && m_hcnt == 0) begin
          chk("m_haddr", d0_haddr, m_addr);
          chk("m_hwrite", 32'(d0_hwrite), 32'(m_wr));
        end
        if (m_busy && m_hcnt == 1) begin
          chk("m_hwdata", d0_hwdata, m_wdata);
          chk("m_mask", 32'(d0_mask), m_wr ? 32'(m_mask) : 32'd0);
        end
        if (m_rdone) chk("m_rdata", d0_rdata, m_rdata);
        m_done = '0; m_err = '0; m_rdone = 1'b0;
        if (!m_busy && any) begin
          m_busy = 1'b1; m_hcnt = 0; m_port = w; m_last = w;
          m_wr    = w ? p1_wr : p0_wr;
          m_addr  = w ? p1_addr : p0_addr;
          m_wdata = w ? p1_wdata : p0_wdata;
          m_mask  = w ? p1_mask : p0_mask;
        end else if (m_busy && hready) begin
          m_hcnt++;
          if (m_hcnt == 2) begin
            m_busy = 1'b0;
            m_done[m_port] = 1'b1;
            m_err[m_port]  = hresp;
            if (!m_wr) begin
              m_rdata = hrdata;
              m_rdone = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq0, seq1;
    rst_n = 1'b0;
    p0_req = 0; p1_req = 0; p0_wr = 0; p1_wr = 0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0; p0_mask = '0; p1_mask = '0;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h12345678;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Port 0 single write, no waits
    p0_req = 1; p0_wr = 1; p0_addr = 32'h100; p0_wdata = 32'h0000AB00; p0_mask = 4'b0010;
    smp(); chk("t1_gnt", 32'(d0_p0_gnt), 32'd1);
    cyc(); p0_req = 0;
    smp(); chk("t1_htrans", 32'(d0_htrans), 32'd2); chk("t1_haddr", d0_haddr, 32'h100);
    cyc();
    smp(); chk("t1_hwdata", d0_hwdata, 32'h0000AB00); chk("t1_mask", 32'(d0_mask), 32'h2);
    cyc();
    smp(); chk("t1_done", 32'(d0_p0_done), 32'd1); chk("t1_err", 32'(d0_p0_err), 32'd0);
    cyc();

    // Port 1 read with two data-phase wait states
    p1_req = 1; p1_wr = 0; p1_addr = 32'h200; p1_mask = 4'hF;
    smp(); chk("t2_gnt", 32'(d0_p1_gnt), 32'd1);
    cyc(); p1_req = 0;
    smp(); chk("t2_htrans", 32'(d0_htrans), 32'd2); chk("t2_haddr", d0_haddr, 32'h200);
    cyc(); hready = 0;
    smp(); chk("t2_mask_c2", 32'(d0_mask), 32'd0);
    cyc();
    smp(); chk("t2_nodone_c3", 32'(d0_p1_done), 32'd0);
    cyc(); hready = 1; hrdata = 32'hDEADBEEF;
    smp(); chk("t2_mask_c4", 32'(d0_mask), 32'd0);
    cyc(); hrdata = 32'h0;
    smp(); chk("t2_done", 32'(d0_p1_done), 32'd1); chk("t2_rdata", d0_rdata, 32'hDEADBEEF);
    cyc();

    // Continuous tie: round-robin alternates, fixed priority always port 0
    p0_req = 1; p0_wr = 1; p0_addr = 32'h10; p0_wdata = 32'h11111111; p0_mask = 4'hF;
    p1_req = 1; p1_wr = 0; p1_addr = 32'h20; hrdata = 32'hCAFEF00D;
    seq0 = '0; seq1 = '0;
    for (int c = 0; c < 13; c++) begin
      smp();
      if (c % 3 == 0 && c < 12) begin
        seq0[(c/3)*2 +: 2] = {d0_p1_gnt, d0_p0_gnt};
        seq1[(c/3)*2 +: 2] = {d1_p1_gnt, d1_p0_gnt};
      end
      cyc();
      if (c == 9) begin p0_req = 0; p1_req = 0; end
    end
    chk("t3_rr_seq", 32'(seq0), 32'h99);
    chk("t3_fp_seq", 32'(seq1), 32'h55);

    // Three address-phase wait states
    p0_req = 1; p0_wr = 0; p0_addr = 32'h300;
    smp(); chk("t4_gnt", 32'(d0_p0_gnt), 32'd1);
    cyc(); p0_req = 0; hready = 0;
    for (int c = 1; c < 5; c++) begin
      smp(); chk("t4_htrans_hold", 32'(d0_htrans), 32'd2); chk("t4_haddr_hold", d0_haddr, 32'h300);
      cyc();
      if (c == 3) hready = 1;
    end
    hrdata = 32'h0BADC0DE;
    smp(); chk("t4_data_htrans", 32'(d0_htrans), 32'd0);
    cyc();
    smp(); chk("t4_done", 32'(d0_p0_done), 32'd1); chk("t4_rdata", d0_rdata, 32'h0BADC0DE);
    cyc();

    // Error response, then same-cycle grant to port 1
    p0_req = 1; p0_wr = 1; p0_addr = 32'h500; p0_wdata = 32'h55; p0_mask = 4'h1;
    smp(); cyc(); p0_req = 0;
    smp(); cyc(); hresp = 1;
    smp(); cyc(); hresp = 0; p1_req = 1; p1_wr = 0; p1_addr = 32'h600;
    smp();
    chk("t5_done", 32'(d0_p0_done), 32'd1); chk("t5_err", 32'(d0_p0_err), 32'd1);
    chk("t5_regrant", 32'(d0_p1_gnt), 32'd1);
    cyc(); p1_req = 0;
    smp(); cyc(); smp(); cyc();
    smp(); chk("t5_p1_done", 32'(d0_p1_done), 32'd1); chk("t5_p1_err", 32'(d0_p1_err), 32'd0);
    cyc();

    // Asynchronous reset during a data phase
    p0_req = 1; p0_wr = 1; p0_addr = 32'h700; p0_wdata = 32'h77; p0_mask = 4'hF;
    smp(); cyc(); p0_req = 0;
    smp(); cyc(); hready = 0;
    smp(); chk("t6_in_data", 32'(d0_mask), 32'hF);
    #2; rst_n = 0; p0_req = 1; p1_req = 1; p1_wr = 0;
    #1;
    chk("t6_async_htrans", 32'(d0_htrans), 32'd0);
    chk("t6_async_haddr", d0_haddr, 32'd0);
    chk("t6_async_hwdata", d0_hwdata, 32'd0);
    chk("t6_async_mask", 32'(d0_mask), 32'd0);
    chk("t6_async_rdata", d0_rdata, 32'd0);
    chk("t6_async_gnt", 32'({d0_p1_gnt, d0_p0_gnt}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1; hready = 1;
    smp();
    chk("t6_tie_after_rst", 32'({d0_p1_gnt, d0_p0_gnt}), 32'd1);
    chk("t6_no_done", 32'({d0_p1_done, d0_p0_done}), 32'd0);
    cyc(); p0_req = 0; p1_req = 0;
    for (int c = 0; c < 5; c++) begin
      smp(); cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/msrv32_dbus_arbiter.md
# msrv32_dbus_arbiter

Two-master sequencer for the MSRV32 data bus. It arbitrates between the core load/store path (port 0, fed by the store unit's aligned data, mask and word address) and a secondary master such as DMA or debug (port 1). It runs each granted request as one AHB-lite-style single transfer: an address phase, then a data phase, with `hready` wait states. Completion and read data are returned to the granted port. It sits between the store/load units and the external data memory interface.

## Interface
- `CORE_PRIORITY`, default 0: 0 = round-robin between ports; 1 = fixed priority, port 0 always wins a tie.
- `ms_riscv32_mp_clk_in`  in  1  single clock; all state updates on the rising edge.
- `ms_riscv32_mp_rst_n_in`  in  1  asynchronous, active-low reset.
- `p0_req_in`, `p1_req_in`  in  1  request valid; held with stable payload until the matching `pX_gnt_out`.
- `p0_wr_in`, `p1_wr_in`  in  1  1 = write, 0 = read.
- `p0_addr_in`, `p1_addr_in`  in  32  word-aligned address.
- `p0_wdata_in`, `p1_wdata_in`  in  32  lane-aligned write data.
- `p0_mask_in`, `p1_mask_in`  in  4  byte write mask (ignored on reads).
- `p0_gnt_out`, `p1_gnt_out`  out  1  request accepted this cycle (combinational, IDLE only).
- `p0_done_out`, `p1_done_out`  out  1  one-cycle completion pulse.
- `p0_err_out`, `p1_err_out`  out  1  valid with done; transfer got an error response.
- `rdata_out`  out  32  read data; valid with either done.
- `ahb_haddr_out`  out  32  registered transfer address.
- `ahb_htrans_out`  out  2  2'b00 IDLE, 2'b10 NONSEQ.
- `ahb_hwrite_out`  out  1  transfer direction.
- `ahb_hwdata_out`  out  32  write data, driven in data phase.
- `ahb_wr_mask_out`  out  4  byte mask, driven in data phase; 0 on reads.
- `ahb_hready_in`  in  1  slave ready; extends the current phase when 0.
- `ahb_hresp_in`  in  1  1 = error; sampled with `hready`=1 in data phase.
- `ahb_hrdata_in`  in  32  read data.

## Operation
- FSM states IDLE, ADDR, DATA.
- IDLE:
  - If any request is present, pick a winner and assert its `gnt` combinationally.
  - At the edge, register addr, wr, wdata and mask; record the winner's port id; go to ADDR.
  - Output `htrans`=00.
- Arbitration:
  - Only one request: it wins.
  - Both requests, `CORE_PRIORITY`=0: the port not granted last time wins. The last-grant pointer resets to port 1, so port 0 wins the first tie.
  - Both requests, `CORE_PRIORITY`=1: port 0 wins.
  - The pointer updates only on a grant.
- ADDR:
  - Drive `htrans`=10, `haddr` and `hwrite` from the registers.
  - `hready`=1 at the edge: go to DATA. Otherwise stay, with address and control held stable.
- DATA:
  - `htrans`=00. Drive `hwdata` and mask from the registers; mask is forced to 0 on reads.
  - `hready`=1 at the edge: register `hrdata` (reads) and `hresp` as err, pulse `done` for the recorded port in the next cycle, go to IDLE.
  - `hready`=0: stay, all outputs stable.
- The done pulse coincides with IDLE, so a new grant can happen in the same cycle.
- `rdata_out` holds its last value until the next read completes. It is undefined for writes and is not cleared.
- A request dropped before its grant is ignored. Payload changes after the grant have no effect.
- Error response: the transfer still completes and `err` pulses with `done`. There is no retry.

## Timing
- Reset (async assert, synchronous release):
  - State IDLE.
  - `htrans`=00; `haddr`, `hwdata`, mask, `hwrite`, `rdata_out` all 0.
  - All `gnt`, `done` and `err` outputs 0.
  - Last-grant pointer = port 1.
- Reset mid-transfer: abort immediately to IDLE with the values above. No done pulse is issued for the aborted transfer.
- Zero-wait latency:
  - Grant in cycle N.
  - ADDR in N+1.
  - DATA in N+2.
  - `done` in N+3.
  - Next grant possible in N+3.
- Maximum throughput: one transfer per 3 cycles.
- Each `hready`=0 cycle in ADDR or DATA adds exactly one cycle.
- Only one `done` can be high in any cycle. `gnt` never asserts outside IDLE.

## Test plan
- Port 0 single write: addr 0x100, wdata 0x0000AB00, mask 0010, no waits.
  - `gnt` in cycle 0, `htrans`=10 with `haddr`=0x100 in cycle 1.
  - `hwdata`=0x0000AB00 and mask 0010 in cycle 2.
  - `p0_done` in cycle 3, err=0.
- Port 1 read of 0x200 with `hready` low for 2 data-phase cycles, `hrdata`=0xDEADBEEF.
  - `p1_done` in cycle 5 with `rdata_out`=0xDEADBEEF; mask 0 throughout.
- Both ports requesting continuously, `CORE_PRIORITY`=0: grants alternate p0, p1, p0, p1 at cycles 0, 3, 6, 9.
  - With `CORE_PRIORITY`=1: p0 at every grant.
- `hready`=0 for 3 cycles in ADDR: `haddr` and `htrans` stay stable, then DATA; done at cycle 6.
- `hresp`=1 with `hready`=1 in data phase of a p0 write: `p0_done` and `p0_err` both pulse in cycle 3, FSM back in IDLE.
- Async reset asserted during DATA: all outputs go to 0 without waiting for a clock edge.
  - No done pulse for the aborted transfer.
  - After release, the first tie is granted to p0.
